// File: rtl/cmd_axis_arbiter.sv
// cmd_axis_arbiter: packet-granular round-robin merge of N_CH AXI-Stream sources, tagged with source id; CMD_ARB_MAXLEN_EN adds over-length truncation.
// Latency: 1 cycle from slave acceptance to m_valid, 1 beat/cycle with no bubble between packets.
// Backpressure: only the granted source sees s_ready, high while the output register is empty or draining.
module cmd_axis_arbiter #(
    parameter int N_CH       = 4,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 8,
    parameter int DEST_WIDTH = 8,
    parameter int MAX_BEATS  = 16
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [N_CH-1:0]              s_valid,
    output logic [N_CH-1:0]              s_ready,
    input  logic [N_CH*DATA_WIDTH-1:0]   s_data,
    input  logic [N_CH*DEST_WIDTH-1:0]   s_dest,
    input  logic [N_CH-1:0]              s_last,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [DATA_WIDTH-1:0]        m_data,
    output logic [ID_WIDTH-1:0]          m_id,
    output logic [DEST_WIDTH-1:0]        m_dest,
    output logic                         m_last,
    output logic                         err_trunc
);
    localparam int PTR_W = $clog2(N_CH);
    localparam int PW1   = PTR_W + 1;
    localparam logic [PTR_W:0]   N_CH_W  = PW1'(N_CH);
    localparam logic [PTR_W-1:0] LAST_CH = PTR_W'(N_CH - 1);

    if (N_CH < 2 || N_CH > 16 || ID_WIDTH < PTR_W || MAX_BEATS < 1) begin : g_bad_cfg
        $error("cmd_axis_arbiter: illegal parameter set");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCKED = 2'd1
`ifdef CMD_ARB_MAXLEN_EN
        ,DRAIN = 2'd2
`endif
    } state_t;

    state_t                state_q, state_d;
    logic [PTR_W-1:0]      grant_q, grant_d;
    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                  m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic [ID_WIDTH-1:0]   m_id_q, m_id_d;
    logic [DEST_WIDTH-1:0] m_dest_q, m_dest_d;
    logic                  m_last_q, m_last_d;

    logic [PTR_W:0]        cand;
    logic [PTR_W-1:0]      arb_idx, grant, next_ptr;
    logic                  arb_found, serving, out_ok, accept, beat_last, draining;

`ifdef CMD_ARB_MAXLEN_EN
    localparam int CNT_W = $clog2(MAX_BEATS + 1);
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             err_trunc_q, err_trunc_d;
    logic             trunc;
    assign draining  = (state_q == DRAIN);
    assign err_trunc = err_trunc_q;
`else
    assign draining  = 1'b0;
    assign err_trunc = 1'b0;
`endif

    // Walk downward so the lowest offset from rr_ptr wins.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            cand = {1'b0, rr_ptr_q} + PW1'(i);
            if (cand >= N_CH_W) cand = cand - N_CH_W;
            if (s_valid[cand[PTR_W-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        grant     = (state_q == IDLE) ? arb_idx : grant_q;
        serving   = (state_q == IDLE) ? arb_found : 1'b1;
        out_ok    = !m_valid_q || m_ready;
        s_ready   = '0;
        if (serving) s_ready[grant] = draining || out_ok;
        accept    = serving && s_valid[grant] && (draining || out_ok);
        beat_last = s_last[grant];
        next_ptr  = (grant == LAST_CH) ? '0 : grant + PTR_W'(1);

        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        m_valid_d = m_valid_q && !m_ready;
        m_data_d  = m_data_q;
        m_id_d    = m_id_q;
        m_dest_d  = m_dest_q;
        m_last_d  = m_last_q;
`ifdef CMD_ARB_MAXLEN_EN
        beat_cnt_d  = beat_cnt_q;
        err_trunc_d = 1'b0;
        trunc       = !beat_last && (beat_cnt_q == CNT_W'(MAX_BEATS - 1));
`endif
        if (accept) begin
            grant_d = grant;
            if (draining) begin
                if (beat_last) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr;
                end
            end else begin
                m_valid_d = 1'b1;
                m_data_d  = s_data[grant*DATA_WIDTH +: DATA_WIDTH];
                m_dest_d  = s_dest[grant*DEST_WIDTH +: DEST_WIDTH];
                m_id_d    = ID_WIDTH'(grant);
                m_last_d  = beat_last;
                if (beat_last) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr;
`ifdef CMD_ARB_MAXLEN_EN
                    beat_cnt_d = '0;
                end else if (trunc) begin
                    // Close the packet downstream here; the source tail is swallowed in DRAIN.
                    m_last_d    = 1'b1;
                    err_trunc_d = 1'b1;
                    beat_cnt_d  = '0;
                    state_d     = DRAIN;
                end else begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    state_d    = LOCKED;
`else
                end else begin
                    state_d = LOCKED;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_id_q      <= '0;
            m_dest_q    <= '0;
            m_last_q    <= 1'b0;
`ifdef CMD_ARB_MAXLEN_EN
            beat_cnt_q  <= '0;
            err_trunc_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_id_q      <= m_id_d;
            m_dest_q    <= m_dest_d;
            m_last_q    <= m_last_d;
`ifdef CMD_ARB_MAXLEN_EN
            beat_cnt_q  <= beat_cnt_d;
            err_trunc_q <= err_trunc_d;
`endif
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_id    = m_id_q;
    assign m_dest  = m_dest_q;
    assign m_last  = m_last_q;
endmodule

// File: tb/tb_cmd_axis_arbiter.sv
// Bench for cmd_axis_arbiter: per-channel source queues feed the DUT, expected output beats are queued in the order the arbitration rules dictate.
// Covers reset, round-robin rotation, packet locking, backpressure stability and (with CMD_ARB_MAXLEN_EN) truncation.
module tb_cmd_axis_arbiter;
    localparam int N_CH = 4, DW = 64, IDW = 8, DESTW = 8, MAXB = 4;
`ifdef CMD_ARB_MAXLEN_EN
    localparam bit TRUNC_EN = 1'b1;
`else
    localparam bit TRUNC_EN = 1'b0;
`endif

    logic                  clk, rstn;
    logic [N_CH-1:0]       s_valid, s_ready, s_last;
    logic [N_CH*DW-1:0]    s_data;
    logic [N_CH*DESTW-1:0] s_dest;
    logic                  m_valid, m_ready, m_last, err_trunc;
    logic [DW-1:0]         m_data;
    logic [IDW-1:0]        m_id;
    logic [DESTW-1:0]      m_dest;

    cmd_axis_arbiter #(.N_CH(N_CH), .DATA_WIDTH(DW), .ID_WIDTH(IDW), .DEST_WIDTH(DESTW), .MAX_BEATS(MAXB)) dut (
        .clk(clk), .rstn(rstn),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_dest(s_dest), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_id(m_id), .m_dest(m_dest),
        .m_last(m_last), .err_trunc(err_trunc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0]    data;
        logic [DESTW-1:0] dest;
        logic             last;
    } beat_t;
    typedef struct packed {
        logic [IDW-1:0]   id;
        logic [DW-1:0]    data;
        logic [DESTW-1:0] dest;
        logic             last;
        logic             err;
    } exp_t;

    beat_t src_q[N_CH][$];
    exp_t  exp_q[$];
    logic [N_CH-1:0] src_en;
    int    mr_mode;   // 0: m_ready=1, 1: random, 2: m_ready=0
    int    checks, errors, err_seen;
    logic  stall_prev;
    logic [DW-1:0]    hold_data;
    logic [IDW-1:0]   hold_id;
    logic [DESTW-1:0] hold_dest;
    logic             hold_last;

    task automatic push_pkt(input int c, input int len, input int pkt);
        logic [DESTW-1:0] d;
        bit    tr;
        int    nout;
        beat_t b;
        exp_t  e;
        d    = DESTW'($urandom_range(0, 255));
        tr   = TRUNC_EN && (len > MAXB);
        nout = tr ? MAXB : len;
        for (int i = 0; i < len; i++) begin
            b.data = {32'($urandom), 8'(c), 8'(pkt), 16'(i)};
            b.dest = d;
            b.last = (i == len - 1);
            src_q[c].push_back(b);
            if (i < nout) begin
                e.id   = IDW'(c);
                e.data = b.data;
                e.dest = d;
                e.last = b.last || (tr && i == MAXB - 1);
                e.err  = tr && (i == MAXB - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    function automatic bit pending();
        bit p;
        p = (exp_q.size() > 0);
        for (int c = 0; c < N_CH; c++)
            if (src_en[c] && src_q[c].size() > 0) p = 1'b1;
        return p;
    endfunction

    task automatic step();
        logic [N_CH-1:0] acc;
        beat_t b;
        exp_t  e;
        @(negedge clk);
        for (int c = 0; c < N_CH; c++) begin
            if (src_en[c] && src_q[c].size() > 0) begin
                b = src_q[c][0];
                s_valid[c] = 1'b1;
                s_data[c*DW +: DW]       = b.data;
                s_dest[c*DESTW +: DESTW] = b.dest;
                s_last[c] = b.last;
            end else begin
                s_valid[c] = 1'b0;
                s_last[c]  = 1'b0;
            end
        end
        m_ready = (mr_mode == 1) ? 1'($urandom_range(0, 1)) : (mr_mode == 0);
        #1;
        acc = s_valid & s_ready;
        checks++;
        if ($countones(s_ready) > 1) begin
            errors++;
            $display("FAIL s_ready_onehot: got %b, required at most one bit set", s_ready);
        end
        if (stall_prev) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== hold_data || m_id !== hold_id ||
                m_dest !== hold_dest || m_last !== hold_last) begin
                errors++;
                $display("FAIL stall_stable: got v=%b d=%h id=%0d last=%b, required v=1 d=%h id=%0d last=%b",
                         m_valid, m_data, m_id, m_last, hold_data, hold_id, hold_last);
            end
        end
        if (m_valid === 1'b1 && m_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: got id=%0d d=%h, required no beat", m_id, m_data);
            end else begin
                e = exp_q.pop_front();
                if (m_id !== e.id || m_data !== e.data || m_dest !== e.dest || m_last !== e.last ||
                    (mr_mode == 0 && err_trunc !== e.err)) begin
                    errors++;
                    $display("FAIL out_beat: got id=%0d d=%h dest=%h last=%b err=%b, required id=%0d d=%h dest=%h last=%b err=%b",
                             m_id, m_data, m_dest, m_last, err_trunc, e.id, e.data, e.dest, e.last, e.err);
                end
            end
        end
        if (err_trunc === 1'b1) err_seen++;
        stall_prev = (m_valid === 1'b1) && !m_ready;
        hold_data = m_data; hold_id = m_id; hold_dest = m_dest; hold_last = m_last;
        @(posedge clk);
        for (int c = 0; c < N_CH; c++)
            if (acc[c]) void'(src_q[c].pop_front());
    endtask

    task automatic run_to_empty(input string name, input int budget, output int n);
        n = 0;
        while (pending() && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (pending()) begin
            errors++;
            $display("FAIL %s_timeout: %0d beats still expected after %0d cycles, required 0", name, exp_q.size(), n);
        end
        repeat (3) step();
    endtask

    task automatic check_err_count(input string name, input int required);
        checks++;
        if (err_seen !== required) begin
            errors++;
            $display("FAIL %s_err_trunc_pulses: got %0d, required %0d", name, err_seen, required);
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        s_valid = '0; s_data = '0; s_dest = '0; s_last = '0; m_ready = 1'b0;
        for (int c = 0; c < N_CH; c++) src_q[c].delete();
        exp_q.delete();
        src_en = '0; stall_prev = 1'b0; err_seen = 0; mr_mode = 0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        int n;
        do_reset();
        @(negedge clk);
        #1;
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b, required 0", m_valid); end
        checks++;
        if (s_ready !== '0) begin errors++; $display("FAIL reset_s_ready: got %b, required 0000", s_ready); end
        checks++;
        if (err_trunc !== 1'b0) begin errors++; $display("FAIL reset_err_trunc: got %b, required 0", err_trunc); end
        checks++;
        if (m_data !== '0 || m_id !== '0 || m_dest !== '0 || m_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_fields: got d=%h id=%0d dest=%h last=%b, required all 0", m_data, m_id, m_dest, m_last);
        end
        // Load one beat of a channel-1 packet and hold it stalled, then reset mid-packet.
        push_pkt(1, 3, 9);
        exp_q.delete();
        mr_mode = 2;
        src_en  = 4'b0010;
        step();
        step();
        #2;
        checks++;
        if (m_valid !== 1'b1 || m_id !== IDW'(1)) begin
            errors++;
            $display("FAIL midpkt_loaded: got v=%b id=%0d, required v=1 id=1", m_valid, m_id);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if (m_valid !== 1'b0 || m_data !== '0 || m_id !== '0 || m_last !== 1'b0 || err_trunc !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got v=%b d=%h id=%0d last=%b err=%b, required all 0",
                     m_valid, m_data, m_id, m_last, err_trunc);
        end
        for (int c = 0; c < N_CH; c++) src_q[c].delete();
        src_en = '0; s_valid = '0; stall_prev = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        // Arbitration restarts from channel 0.
        mr_mode = 0;
        push_pkt(0, 1, 1);
        push_pkt(2, 1, 1);
        src_en = '1;
        run_to_empty("reset_restart", 20, n);
        check_err_count("reset", 0);
    endtask

    task automatic test_round_robin();
        int n;
        do_reset();
        for (int p = 0; p < 3; p++)
            for (int c = 0; c < N_CH; c++) push_pkt(c, 1, p);
        src_en = '1;
        run_to_empty("round_robin", 60, n);
        checks++;
        if (n !== 13) begin
            errors++;
            $display("FAIL rr_throughput: got %0d cycles for 12 beats, required 13", n);
        end
        check_err_count("round_robin", 0);
    endtask

    task automatic test_packet_lock();
        int n;
        do_reset();
        src_en = '1;
        push_pkt(0, 1, 0);
        run_to_empty("lock_pre", 20, n);
        push_pkt(2, 5, 1);
        push_pkt(0, 1, 1);
        push_pkt(3, 1, 1);
        src_en = 4'b0101;
        n = 0;
        while (pending() && n < 60) begin
            if (src_q[0].size() == 0) src_en[3] = 1'b1;
            step();
            n++;
        end
        checks++;
        if (pending()) begin
            errors++;
            $display("FAIL lock_timeout: %0d beats still expected after %0d cycles, required 0", exp_q.size(), n);
        end
        repeat (3) step();
        check_err_count("lock", 0);
    endtask

    task automatic test_backpressure();
        int n;
        do_reset();
        for (int p = 0; p < 4; p++) begin
            push_pkt(1, 3, p);
            push_pkt(3, 3, p);
        end
        src_en  = '1;
        mr_mode = 1;
        run_to_empty("backpressure", 400, n);
        check_err_count("backpressure", 0);
    endtask

`ifdef CMD_ARB_MAXLEN_EN
    task automatic test_truncate();
        int n;
        do_reset();
        push_pkt(1, 7, 0);
        push_pkt(2, 1, 0);
        push_pkt(3, 1, 0);
        push_pkt(0, 1, 0);
        src_en = 4'b0010;
        step();
        src_en = '1;
        run_to_empty("truncate", 80, n);
        check_err_count("truncate", 1);
    endtask

    task automatic test_exact_max();
        int n;
        do_reset();
        push_pkt(1, MAXB, 0);
        push_pkt(2, 1, 0);
        src_en = '1;
        run_to_empty("exact_max", 40, n);
        check_err_count("exact_max", 0);
    endtask
`else
    task automatic test_long_packet();
        int n;
        do_reset();
        push_pkt(0, 20, 0);
        push_pkt(1, 2, 0);
        src_en = '1;
        run_to_empty("long_packet", 80, n);
        check_err_count("long_packet", 0);
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_round_robin();
        test_packet_lock();
        test_backpressure();
`ifdef CMD_ARB_MAXLEN_EN
        test_truncate();
        test_exact_max();
`else
        test_long_packet();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1);
    end
endmodule
